// File: rtl/aes_round_ctrl_if.sv
// Stream interface for aes_round_ctrl: plaintext/key in, ciphertext out.
interface aes_round_ctrl_if;
  localparam int unsigned BLK_W = 128;

  logic             in_valid;
  logic             in_ready;
  logic [BLK_W-1:0] in_state;
  logic [BLK_W-1:0] in_key;
  logic             out_valid;
  logic             out_ready;
  logic [BLK_W-1:0] out_data;

  // Producer/consumer side
  modport master (
    output in_valid, in_state, in_key, out_ready,
    input  in_ready, out_valid, out_data
  );

  // Controller side
  modport slave (
    input  in_valid, in_state, in_key, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryption controller driving one shared external round
// datapath. Optional macro AES_CTRL_B2B_EN lets a new block be accepted in
// the same cycle the previous ciphertext is handed off.
module aes_round_ctrl (
  input  logic                   clk,
  input  logic                   rst,
  aes_round_ctrl_if.slave        bus,
  output logic                   busy,
  output logic [3:0]             round_idx,
  output logic [127:0]           dp_state,
  output logic [127:0]           dp_key,
  output logic [7:0]             dp_rc,
  output logic                   dp_final,
  input  logic [127:0]           dp_state_out,
  input  logic [127:0]           dp_key_out
);

  localparam int unsigned NUM_ROUNDS = 10;
  localparam int unsigned BLK_W      = 128;
  localparam int unsigned RND_W      = 4;
  localparam int unsigned RC_W       = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [BLK_W-1:0] st_reg;
  logic [BLK_W-1:0] key_reg;
  logic [RND_W-1:0] rnd;
  logic [RC_W-1:0]  rc;
  logic             idle_q;
  logic             done_q;
  logic             in_ready_c;
  logic             accept_c;

  // GF(2^8) doubling used to step the round constant
  function automatic logic [RC_W-1:0] xtime(input logic [RC_W-1:0] b);
    return {b[RC_W-2:0], 1'b0} ^ (b[RC_W-1] ? 8'h1b : 8'h00);
  endfunction

  // Input readiness: optionally overlap accept with the output handshake
`ifdef AES_CTRL_B2B_EN
  assign in_ready_c = idle_q || (done_q && bus.out_ready);
`else
  assign in_ready_c = idle_q;
`endif

  assign accept_c      = bus.in_valid && in_ready_c;
  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = done_q;
  assign bus.out_data  = st_reg;
  assign dp_state      = st_reg;
  assign dp_key        = key_reg;
  assign dp_rc         = rc;
  assign round_idx     = rnd;

  // Round sequencer: load on accept, iterate the datapath, hold result
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      st_reg   <= '0;
      key_reg  <= '0;
      rnd      <= '0;
      rc       <= 8'h01;
      idle_q   <= 1'b1;
      done_q   <= 1'b0;
      busy     <= 1'b0;
      dp_final <= 1'b0;
    end else if (accept_c) begin
      state    <= ROUND;
      st_reg   <= bus.in_state ^ bus.in_key;
      key_reg  <= bus.in_key;
      rnd      <= RND_W'(1);
      rc       <= 8'h01;
      idle_q   <= 1'b0;
      done_q   <= 1'b0;
      busy     <= 1'b1;
      dp_final <= (NUM_ROUNDS == 1);
    end else begin
      case (state)
        ROUND: begin
          st_reg  <= dp_state_out;
          key_reg <= dp_key_out;
          rc      <= xtime(rc);
          if (rnd == RND_W'(NUM_ROUNDS)) begin
            state    <= DONE;
            rnd      <= '0;
            busy     <= 1'b0;
            done_q   <= 1'b1;
            dp_final <= 1'b0;
          end else begin
            rnd      <= rnd + RND_W'(1);
            dp_final <= (rnd == RND_W'(NUM_ROUNDS - 1));
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state  <= IDLE;
            done_q <= 1'b0;
            idle_q <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Iterative AES-128 encryption controller. Accepts a plaintext/key pair over a valid/ready handshake, performs the initial AddRoundKey, then runs one shared external round datapath (SubBytes/ShiftRows/MixColumns/AddRoundKey plus key expansion) ten times, one round per clock. It sequences the round count, round constant and final-round flag (no MixColumns), and holds the ciphertext until the consumer accepts it. This replaces the unrolled ten-instance chain with one round instance and this controller.

## Interface
- NUM_ROUNDS, 10, number of datapath passes after the initial key add; only 10 (AES-128) is supported.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  plaintext/key offered.
- in_ready  out  1  controller can accept; high only in IDLE (see Configuration).
- in_state  in  128  plaintext, byte 15 = first byte.
- in_key  in  128  cipher key, same byte order.
- out_valid  out  1  ciphertext available.
- out_ready  in  1  consumer accepts ciphertext.
- out_data  out  128  ciphertext.
- busy  out  1  high in ROUND.
- round_idx  out  4  current round number, 1..10 in ROUND, 0 otherwise.
- dp_state  out  128  state to round datapath (= state register).
- dp_key  out  128  previous round key to datapath (= key register).
- dp_rc  out  8  round constant for this round's key expansion.
- dp_final  out  1  high when round_idx == NUM_ROUNDS; datapath skips MixColumns.
- dp_state_out  in  128  datapath round result (combinational from dp_*).
- dp_key_out  in  128  expanded round key from datapath.

## Operation
- FSM states: IDLE, ROUND, DONE.
- IDLE: in_ready=1. On in_valid && in_ready: st_reg <= in_state ^ in_key; key_reg <= in_key; rnd <= 1; rc <= 8'h01; go ROUND.
- ROUND: each cycle st_reg <= dp_state_out; key_reg <= dp_key_out; rc <= xtime(rc) = {rc[6:0],1'b0} ^ (rc[7] ? 8'h1b : 8'h00); rnd <= rnd+1. When rnd == NUM_ROUNDS, capture, then go DONE; rnd <= 0.
- rc sequence over rounds 1..10: 01,02,04,08,10,20,40,80,1b,36.
- DONE: out_valid=1, out_data=st_reg, stable until handshake. On out_valid && out_ready: go IDLE.
- in_valid outside the accepting state is ignored; in_state/in_key are not sampled.
- out_ready outside DONE has no effect.
- round_idx = rnd; dp_final = (state==ROUND && rnd==NUM_ROUNDS).

## Timing
- Reset (rst high at edge): state IDLE, st_reg=0, key_reg=0, rnd=0, rc=8'h01. Outputs after reset: in_ready=1, out_valid=0, out_data=0, busy=0, round_idx=0, dp_state=0, dp_key=0, dp_rc=8'h01, dp_final=0.
- rst has priority over all other events, including mid-ROUND and mid-DONE; the in-flight block is discarded and no out_valid is produced.
- Accept at edge T0; rounds 1..10 are captured at edges T1..T10; out_valid is high from T10 on. Latency is 10 cycles from accept to out_valid.
- Without B2B, the earliest next accept is at the edge after the output handshake, giving 12 cycles per block at full throughput.
- The datapath is purely combinational within one cycle; the controller adds no stall cycles.

## Configuration
- AES_CTRL_B2B_EN defined: in_ready = (IDLE) || (DONE && out_ready).
  - In DONE, a simultaneous output handshake and input accept loads the new block and goes straight to ROUND.
  - Throughput is 11 cycles per block.
- Not defined: in_ready is high only in IDLE. One idle cycle separates blocks.

## Test plan
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, out_ready=1 -> out_valid exactly 10 cycles after accept, out_data 69c4e0d86a7b0430d8cdb78070b4c55a; dp_rc per round 01,02,04,08,10,20,40,80,1b,36; dp_final only in round 10.
- Backpressure: same vector, out_ready=0 for 5 cycles after out_valid -> out_valid and out_data held constant, in_ready=0; out_ready=1 -> IDLE next cycle, out_valid=0.
- Busy rejection: in_valid held high with a different key during ROUND -> no change to key_reg or rnd; result still matches the first vector.
- Reset mid-operation: assert rst when round_idx=5 -> next cycle busy=0, in_ready=1, out_valid=0, round_idx=0; a new C.1 vector then completes correctly.
- Back-to-back, two C.1 blocks with in_valid=1 and out_ready=1 continuously:
  - AES_CTRL_B2B_EN defined: accepts 11 cycles apart.
  - Not defined: accepts 12 cycles apart.
  - Both ciphertexts = 69c4e0d86a7b0430d8cdb78070b4c55a.
